machine_ctl: RTL and testbench
==============================

# machine_ctl

Instruction-sequencing controller for the 8-bit accumulator CPU. It steps every instruction through a fixed 8-cycle state sequence and generates the fetch, PC, memory, accumulator and ALU strobes. It sits directly upstream of the ALU and drives its `alu_ena`. It consumes the 3-bit opcode from the instruction register and the ALU's `zero` flag, using the same opcode encoding as the ALU: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.

## Interface
Parameters:
- none; opcode width is fixed at 3 bits and the instruction length at 8 cycles.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  run enable; sampled only in IDLE and at the end of S7
- opcode  in  3  opcode field from the instruction register
- zero  in  1  accumulator-is-zero flag from the ALU
- rd  out  1  memory read strobe
- wr  out  1  memory write strobe
- load_ir  out  1  instruction register load
- inc_pc  out  1  program counter increment
- load_pc  out  1  program counter load (jump)
- load_acc  out  1  accumulator load from ALU result
- alu_ena  out  1  ALU evaluate enable
- datactl_ena  out  1  accumulator-to-data-bus driver enable
- halt  out  1  processor halted

## Operation
States:
- IDLE: initial state; all outputs 0.
- S0–S7: the 8 steps of one instruction.
- HALTED: terminal state after an HLT instruction.

Transitions:
- IDLE: goes to S0 when ena=1, otherwise stays in IDLE.
- Sk goes to Sk+1 unconditionally for k=0..6.
- S7 goes to HALTED if the latched opcode is HLT.
- Otherwise S7 goes to S0 if ena=1, or to IDLE if ena=0.
- HALTED is left only by reset.
- ena changing during S0–S6 is ignored; the current instruction always completes.

Internal latches:
- The opcode is latched on the edge entering S3. The IR is valid after S1, and the latched value governs S3–S7.
- zero is latched on the edge entering S4. Both SKZ increments use this latched copy, even if zero changes later.

Outputs per state (any output not listed is 0):
- S0: rd, load_ir. Fetches the high byte.
- S1: rd, load_ir, inc_pc. Fetches the low byte.
- S2: none.
- S3: inc_pc; also halt if the opcode is HLT.
- ADD/AND/XOR/LDA: S4 rd and alu_ena; S5 rd and load_acc; S6 rd; S7 none.
- STO: S4 datactl_ena; S5 wr and datactl_ena; S6 datactl_ena; S7 none.
- JMP: S4 load_pc; S5 load_pc; S6 and S7 none.
- SKZ: inc_pc equals latched zero in S5 and in S7. This skips one 2-byte instruction.
- HLT: halt in S4–S7, then halt=1 continuously in HALTED with every other output 0.

Invariants:
- wr and rd are never both 1.
- load_pc and inc_pc are never both 1.

## Timing
- All outputs are registered. The values listed for state Sk are valid for the whole cycle following the edge that enters Sk, and contain no combinational glitches.
- Reset: rst_n=0 immediately forces state IDLE, every output to 0, and the latched opcode and zero to 0, regardless of the current state. This includes reset asserted mid-instruction and reset in HALTED.
- Start latency: ena=1 sampled at edge E0 while in IDLE gives rd=load_ir=1 in the cycle after E0.
- Throughput: one instruction per 8 cycles with no bubble between instructions while ena stays 1.
- The first rd of the next instruction follows S7 directly.
- ALU handshake: alu_ena is high for exactly one cycle (S4), and load_acc is high in the following cycle (S5). The accumulator therefore captures the ALU output registered at the end of S4.

## Test plan
- Reset: assert rst_n=0 during S5 of an ADD -> all outputs 0 before the next clock. Release with ena=1 -> the first edge gives rd=1 and load_ir=1 (S0).
- ADD (opcode 010) with ena=1 held for 16 cycles -> two identical 8-cycle patterns. alu_ena=1 only in S4 and load_acc=1 only in S5. inc_pc pulses only in S1 and S3.
- Drop ena to 0 during S3 of an ADD -> the instruction completes through S7, then IDLE with all outputs 0. Raising ena later restarts at S0.
- SKZ (001) with zero=1 at S4 entry, then zero forced to 0 in S5 -> inc_pc in S1, S3, S5 and S7 (4 pulses). Repeating with zero=0 -> inc_pc in S1 and S3 only.
- STO (110) -> datactl_ena in S4–S6 and wr only in S5, with no rd in S4–S7. JMP (111) -> load_pc in S4 and S5, and inc_pc never coincides with load_pc.
- HLT (000) -> halt rises in S3 and stays 1 for 20 or more cycles after S7 with ena=1, with no further rd or load_ir. Only rst_n=0 clears halt.

Source files
------------

// File: rtl/machine_ctl.sv
// machine_ctl: fixed 8-step instruction sequencer for the 8-bit accumulator CPU.
// Every strobe is registered.
// The register is loaded with the decode of the state being entered,
// so each output is glitch-free and valid for the whole cycle of that state.
module machine_ctl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       alu_ena,
  output logic       datactl_ena,
  output logic       halt
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7,
    ST_HALTED
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       zero_q, zero_d;

  logic rd_q, wr_q, load_ir_q, inc_pc_q, load_pc_q;
  logic load_acc_q, alu_ena_q, datactl_ena_q, halt_q;
  logic rd_d, wr_d, load_ir_d, inc_pc_d, load_pc_d;
  logic load_acc_d, alu_ena_d, datactl_ena_d, halt_d;

  // Next-state sequencing plus the opcode (captured leaving S2) and zero (captured leaving S3) latches.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: state_d = ena ? ST_S0 : ST_IDLE;
      ST_S0:   state_d = ST_S1;
      ST_S1:   state_d = ST_S2;
      ST_S2: begin
        state_d = ST_S3;
        op_d    = opcode;
      end
      ST_S3: begin
        state_d = ST_S4;
        zero_d  = zero;
      end
      ST_S4:   state_d = ST_S5;
      ST_S5:   state_d = ST_S6;
      ST_S6:   state_d = ST_S7;
      ST_S7: begin
        if (op_q == OP_HLT) state_d = ST_HALTED;
        else if (ena)       state_d = ST_S0;
        else                state_d = ST_IDLE;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Strobe decode for the state about to be entered, using the latch values that will hold there.
  always_comb begin
    rd_d          = 1'b0;
    wr_d          = 1'b0;
    load_ir_d     = 1'b0;
    inc_pc_d      = 1'b0;
    load_pc_d     = 1'b0;
    load_acc_d    = 1'b0;
    alu_ena_d     = 1'b0;
    datactl_ena_d = 1'b0;
    halt_d        = 1'b0;
    case (state_d)
      ST_S0: begin
        rd_d      = 1'b1;
        load_ir_d = 1'b1;
      end
      ST_S1: begin
        rd_d      = 1'b1;
        load_ir_d = 1'b1;
        inc_pc_d  = 1'b1;
      end
      ST_S3: begin
        inc_pc_d = 1'b1;
        halt_d   = (op_d == OP_HLT);
      end
      ST_S4: begin
        case (op_d)
          OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
            rd_d      = 1'b1;
            alu_ena_d = 1'b1;
          end
          OP_STO:  datactl_ena_d = 1'b1;
          OP_JMP:  load_pc_d     = 1'b1;
          OP_HLT:  halt_d        = 1'b1;
          default: ;
        endcase
      end
      ST_S5: begin
        case (op_d)
          OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
            rd_d       = 1'b1;
            load_acc_d = 1'b1;
          end
          OP_STO: begin
            wr_d          = 1'b1;
            datactl_ena_d = 1'b1;
          end
          OP_JMP:  load_pc_d = 1'b1;
          OP_SKZ:  inc_pc_d  = zero_d;
          OP_HLT:  halt_d    = 1'b1;
          default: ;
        endcase
      end
      ST_S6: begin
        case (op_d)
          OP_ADD, OP_AND, OP_XOR, OP_LDA: rd_d = 1'b1;
          OP_STO:  datactl_ena_d = 1'b1;
          OP_HLT:  halt_d        = 1'b1;
          default: ;
        endcase
      end
      ST_S7: begin
        case (op_d)
          OP_SKZ:  inc_pc_d = zero_d;
          OP_HLT:  halt_d   = 1'b1;
          default: ;
        endcase
      end
      ST_HALTED: halt_d = 1'b1;
      default: ;
    endcase
  end

  // State, latches and output strobes; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= 3'b000;
      zero_q        <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      load_ir_q     <= 1'b0;
      inc_pc_q      <= 1'b0;
      load_pc_q     <= 1'b0;
      load_acc_q    <= 1'b0;
      alu_ena_q     <= 1'b0;
      datactl_ena_q <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      zero_q        <= zero_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      load_ir_q     <= load_ir_d;
      inc_pc_q      <= inc_pc_d;
      load_pc_q     <= load_pc_d;
      load_acc_q    <= load_acc_d;
      alu_ena_q     <= alu_ena_d;
      datactl_ena_q <= datactl_ena_d;
      halt_q        <= halt_d;
    end
  end

  assign rd          = rd_q;
  assign wr          = wr_q;
  assign load_ir     = load_ir_q;
  assign inc_pc      = inc_pc_q;
  assign load_pc     = load_pc_q;
  assign load_acc    = load_acc_q;
  assign alu_ena     = alu_ena_q;
  assign datactl_ena = datactl_ena_q;
  assign halt        = halt_q;

endmodule

// File: tb/tb_machine_ctl.sv
// Directed bench for machine_ctl.
// Expected strobe vectors are queued as each cycle's stimulus is driven.
// Each vector is popped and compared one time unit after the clock edge.
module tb_machine_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic rd, wr, load_ir, inc_pc, load_pc, load_acc, alu_ena, datactl_ena, halt;

  always #5 clk = ~clk;

  machine_ctl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .opcode      (opcode),
    .zero        (zero),
    .rd          (rd),
    .wr          (wr),
    .load_ir     (load_ir),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .alu_ena     (alu_ena),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  // Vector order: {rd, wr, load_ir, inc_pc, load_pc, load_acc, alu_ena, datactl_ena, halt}
  localparam logic [8:0] V_RD   = 9'h100;
  localparam logic [8:0] V_WR   = 9'h080;
  localparam logic [8:0] V_LIR  = 9'h040;
  localparam logic [8:0] V_INC  = 9'h020;
  localparam logic [8:0] V_LPC  = 9'h010;
  localparam logic [8:0] V_LACC = 9'h008;
  localparam logic [8:0] V_ALU  = 9'h004;
  localparam logic [8:0] V_DCT  = 9'h002;
  localparam logic [8:0] V_HLT  = 9'h001;
  localparam logic [8:0] V_NONE = 9'h000;

  typedef struct {
    logic [8:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [8:0] obs();
    return {rd, wr, load_ir, inc_pc, load_pc, load_acc, alu_ena, datactl_ena, halt};
  endfunction

  // Build an 8-state expectation; S0..S2 are the same for every instruction.
  function automatic logic [7:0][8:0] mk(input logic [8:0] s3, input logic [8:0] s4,
                                         input logic [8:0] s5, input logic [8:0] s6,
                                         input logic [8:0] s7);
    return {s7, s6, s5, s4, s3, V_NONE, V_RD | V_LIR | V_INC, V_RD | V_LIR};
  endfunction

  task automatic check(input logic [8:0] got, input logic [8:0] want, input string tag);
    checks++;
    assert (got === want)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, got, want);
      end
  endtask

  task automatic check_bit(input logic got, input logic want, input string tag);
    checks++;
    assert (got === want)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, got, want);
      end
  endtask

  // One clock: drive inputs, queue the expectation, then compare after the edge.
  task automatic cyc(input logic en, input logic [2:0] op, input logic z,
                     input logic [8:0] want, input string tag);
    exp_t e;
    ena    = en;
    opcode = op;
    zero   = z;
    sb.push_back('{want, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(obs(), e.v, e.tag);
    check_bit(rd & wr, 1'b0, {e.tag, "_rd_wr_excl"});
    check_bit(load_pc & inc_pc, 1'b0, {e.tag, "_pc_excl"});
  endtask

  // Run n steps of an instruction.
  // ena is random while it must be ignored, and opcode/zero are random outside their latch edges.
  task automatic instr(input logic [2:0] op, input logic z4, input logic zl,
                       input logic [7:0][8:0] exp, input int n, input string name);
    logic       en;
    logic [2:0] opx;
    logic       zx;
    for (int k = 0; k < n; k++) begin
      en  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      opx = (k == 3) ? op : 3'($urandom_range(0, 7));
      if (k == 4)     zx = z4;
      else if (k > 4) zx = zl;
      else            zx = 1'($urandom_range(0, 1));
      cyc(en, opx, zx, exp[k], $sformatf("%s_S%0d", name, k));
    end
    $display("txn %s op=%b z4=%b zlate=%b steps=%0d errors=%0d", name, op, z4, zl, n, errors);
  endtask

  logic [7:0][8:0] e_alu, e_sto, e_jmp, e_skz1, e_skz0, e_hlt;

  initial begin
    e_alu  = mk(V_INC, V_RD | V_ALU, V_RD | V_LACC, V_RD, V_NONE);
    e_sto  = mk(V_INC, V_DCT, V_WR | V_DCT, V_DCT, V_NONE);
    e_jmp  = mk(V_INC, V_LPC, V_LPC, V_NONE, V_NONE);
    e_skz1 = mk(V_INC, V_NONE, V_INC, V_NONE, V_INC);
    e_skz0 = mk(V_INC, V_NONE, V_NONE, V_NONE, V_NONE);
    e_hlt  = mk(V_INC | V_HLT, V_HLT, V_HLT, V_HLT, V_HLT);

    // Reset state, and reset holding against ena=1.
    rst_n  = 1'b0;
    ena    = 1'b0;
    opcode = 3'b000;
    zero   = 1'b0;
    #2;
    check(obs(), V_NONE, "reset_initial");
    ena = 1'b1;
    @(posedge clk);
    #1;
    check(obs(), V_NONE, "reset_hold_ena");
    rst_n = 1'b1;

    // Back-to-back ADDs: two identical patterns, no bubble.
    instr(3'b010, 1'b0, 1'b0, e_alu, 8, "add_a");
    instr(3'b010, 1'b1, 1'b0, e_alu, 8, "add_b");

    // ADD then ena low at the end of S7: go idle, then restart.
    instr(3'b010, 1'b0, 1'b1, e_alu, 8, "add_drop");
    cyc(1'b0, 3'b010, 1'b0, V_NONE, "idle_after_drop");
    cyc(1'b0, 3'b111, 1'b1, V_NONE, "idle_hold");
    instr(3'b101, 1'b0, 1'b0, e_alu, 8, "lda");

    // SKZ with zero latched high then dropped; then latched low then raised.
    instr(3'b001, 1'b1, 1'b0, e_skz1, 8, "skz_z1");
    instr(3'b001, 1'b0, 1'b1, e_skz0, 8, "skz_z0");

    instr(3'b110, 1'b0, 1'b0, e_sto, 8, "sto");
    instr(3'b111, 1'b1, 1'b1, e_jmp, 8, "jmp");
    instr(3'b011, 1'b1, 1'b0, e_alu, 8, "and");
    instr(3'b100, 1'b0, 1'b1, e_alu, 8, "xor");

    // Reset during S5 of an ADD clears outputs without waiting for a clock.
    instr(3'b010, 1'b0, 1'b0, e_alu, 6, "add_to_s5");
    #2;
    rst_n = 1'b0;
    #1;
    check(obs(), V_NONE, "reset_mid_async");
    @(posedge clk);
    #1;
    check(obs(), V_NONE, "reset_mid_hold");
    rst_n = 1'b1;
    instr(3'b010, 1'b0, 1'b0, e_alu, 8, "add_after_reset");

    // HLT: halt from S3, then sticky in HALTED with no fetches.
    instr(3'b000, 1'b0, 1'b0, e_hlt, 8, "hlt");
    for (int i = 0; i < 22; i++)
      cyc(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), V_HLT,
          $sformatf("halted_%0d", i));
    #2;
    rst_n = 1'b0;
    #1;
    check(obs(), V_NONE, "reset_in_halted");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 3'b010, 1'b0, V_RD | V_LIR, "restart_after_halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
